// File: rtl/fir_xifu_mem_responder.sv
// Core-side CV-X-IF memory responder: one holding register feeding a single OBI port, in-order results.
// Optional misalignment trap: define FIR_XIFU_MEMRESP_MISALIGN_ERR_EN.
module fir_xifu_mem_responder #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int ADDR_WIDTH      = 32,
   parameter int ID_WIDTH        = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   // xif_mem (cpu_mem)
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [ID_WIDTH-1:0]   mem_req_id,
   input  logic [ADDR_WIDTH-1:0] mem_req_addr,
   input  logic                  mem_req_we,
   input  logic [2:0]            mem_req_size,
   input  logic [3:0]            mem_req_be,
   input  logic [31:0]           mem_req_wdata,
   output logic                  mem_resp_exc,
   output logic [5:0]            mem_resp_exccode,
   output logic                  mem_resp_dbg,
   // xif_mem_result (cpu_mem_result)
   output logic                  mem_result_valid,
   output logic [ID_WIDTH-1:0]   mem_result_id,
   output logic [31:0]           mem_result_rdata,
   output logic                  mem_result_err,
   output logic                  mem_result_dbg,
   // OBI data port
   output logic                  obi_req_o,
   input  logic                  obi_gnt_i,
   output logic [ADDR_WIDTH-1:0] obi_addr_o,
   output logic                  obi_we_o,
   output logic [3:0]            obi_be_o,
   output logic [31:0]           obi_wdata_o,
   input  logic                  obi_rvalid_i,
   input  logic [31:0]           obi_rdata_i,
   input  logic                  obi_err_i,
   // FSM state observation
   output logic                  state_dbg
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

   state_t              state;
   state_t              state_next;
   logic [ID_WIDTH-1:0] hold_id;
   logic [ID_WIDTH-1:0] fifo_id [MAX_OUTSTANDING];
   logic                fifo_we [MAX_OUTSTANDING];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [CNT_W-1:0]    count;
   logic [CNT_W-1:0]    count_next;
   logic                granted;
   logic                hold_free;
   logic                handshake;
   logic                forward;
   logic                misaligned;
   logic                push;
   logic                pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // Handshake/valid-ready: a request transfers in any cycle where mem_valid && mem_ready;
   // a result is presented for exactly one cycle and is never back-pressured.
   assign granted   = (state == REQ) && obi_req_o && obi_gnt_i;
   assign hold_free = (state == IDLE) || granted;
   assign mem_ready = hold_free && (count < MAX_CNT) && !clear_i;
   assign handshake = mem_valid && mem_ready;
   assign forward   = handshake && !misaligned;
   assign push      = granted;
   assign pop       = obi_rvalid_i && (count != '0);

   assign mem_resp_dbg   = 1'b0;
   assign mem_result_dbg = 1'b0;
   assign state_dbg      = state;

`ifdef FIR_XIFU_MEMRESP_MISALIGN_ERR_EN
   always_comb begin
      misaligned = 1'b0;
      case (mem_req_size)
         3'd1:    misaligned = mem_req_addr[0];
         3'd2:    misaligned = |mem_req_addr[1:0];
         default: misaligned = 1'b0;
      endcase
   end

   assign mem_resp_exc     = misaligned;
   assign mem_resp_exccode = misaligned ? (mem_req_we ? 6'd6 : 6'd4) : 6'd0;
`else
   logic unused_req_bits;

   assign misaligned       = 1'b0;
   assign mem_resp_exc     = 1'b0;
   assign mem_resp_exccode = 6'd0;
   assign unused_req_bits  = ^{mem_req_addr[1:0], mem_req_size};
`endif

   always_comb begin
      count_next = count;
      if (push && !pop) begin
         count_next = count + 1'b1;
      end else if (!push && pop) begin
         count_next = count - 1'b1;
      end
   end

   // A granted request always leaves REQ; clear only drops a request OBI has not taken.
   always_comb begin
      state_next = state;
      if (forward) begin
         state_next = REQ;
      end else if (granted || clear_i) begin
         state_next = IDLE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state            <= IDLE;
         obi_req_o        <= 1'b0;
         obi_addr_o       <= '0;
         obi_we_o         <= 1'b0;
         obi_be_o         <= '0;
         obi_wdata_o      <= '0;
         hold_id          <= '0;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         count            <= '0;
         mem_result_valid <= 1'b0;
         mem_result_id    <= '0;
         mem_result_rdata <= '0;
         mem_result_err   <= 1'b0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            fifo_id[i] <= '0;
            fifo_we[i] <= 1'b0;
         end
      end else begin
         state <= state_next;
         count <= count_next;
         // Hold the request off the bus while the ID FIFO is full so a grant can never overflow it.
         obi_req_o <= (state_next == REQ) && (count_next < MAX_CNT);

         if (forward) begin
            hold_id     <= mem_req_id;
            obi_addr_o  <= {mem_req_addr[ADDR_WIDTH-1:2], 2'b00};
            obi_we_o    <= mem_req_we;
            obi_be_o    <= mem_req_be;
            obi_wdata_o <= mem_req_wdata;
         end

         if (push) begin
            fifo_id[wr_ptr] <= hold_id;
            fifo_we[wr_ptr] <= obi_we_o;
            wr_ptr          <= ptr_inc(wr_ptr);
         end

         mem_result_valid <= pop;
         if (pop) begin
            mem_result_id    <= fifo_id[rd_ptr];
            mem_result_rdata <= fifo_we[rd_ptr] ? 32'h0 : obi_rdata_i;
            mem_result_err   <= obi_err_i;
            rd_ptr           <= ptr_inc(rd_ptr);
         end
      end
   end

`ifndef SYNTHESIS
   rvalid_needs_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
      obi_rvalid_i |-> (count != '0));
   push_never_overflows: assert property (@(posedge clk_i) disable iff (!rst_ni)
      push |-> ((count < MAX_CNT) || pop));
`endif

endmodule
